// File: rtl/alu_exec_unit_if.sv
// Decoder-to-ALU handshake bundle: request side (operation/operands) and
// response side (registered result plus status).
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, operation, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op, busy
    );

    modport slave (
        input  in_valid, operation, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal_op, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, WIDTH-cycle shift-add MUL,
// valid/ready on both sides with a registered result.
//
// state | meaning
// IDLE  | can accept an op when the output register is free or draining
// MUL   | shift-add multiply in flight, one multiplier bit per cycle
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic             op_ill;
    logic [WIDTH-1:0] acc_next;

    assign bus.in_ready   = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_q;
    assign bus.busy       = busy_q;

    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        case (bus.operation)
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            OP_ADD:  op_res = bus.a + bus.b;
            OP_SUB:  op_res = bus.a + ~bus.b + WIDTH'(1);
            OP_MUL:  op_res = '0;
            default: op_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Drain first; a same-edge accept or MUL completion overrides it.
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.operation == OP_MUL) begin
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            acc    <= '0;
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result_q    <= op_res;
                            zero_q      <= (op_res == '0);
                            illegal_q   <= op_ill;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        result_q    <= acc_next;
                        zero_q      <= (acc_next == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        count       <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes hand-computed responses,
// a monitor pops and compares on every output handshake.
module tb_alu_exec_unit;
    localparam int WIDTH = 64;

    logic clk;
    logic reset;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed when out_valid && out_ready at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected none", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.result, e.res);
                    check("zero", WIDTH'(bus.zero), WIDTH'(e.zero));
                    check("illegal_op", WIDTH'(bus.illegal_op), WIDTH'(e.ill));
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] er,
                         input logic ez, input logic ei, input bit push,
                         output int waits);
        exp_t e;
        waits = 0;
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.a         = av;
        bus.b         = bv;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
                break;
            end
        end
        if (push && waits <= 200) begin
            e.res = er; e.zero = ez; e.ill = ei;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int w;
    int busy_cycles;

    initial begin
        bus.in_valid  = 1'b0;
        bus.operation = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        check("rst_out_valid", WIDTH'(bus.out_valid), 0);
        check("rst_result", bus.result, 0);
        check("rst_busy", WIDTH'(bus.busy), 0);
        check("rst_in_ready", WIDTH'(bus.in_ready), 1);

        // Reset mid-multiply discards the partial product.
        issue(4'b1000, 7, 9, 63, 0, 0, 0, w);
        step(9);
        check("mul_busy_before_reset", WIDTH'(bus.busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #1;
        check("rmul_busy", WIDTH'(bus.busy), 0);
        check("rmul_out_valid", WIDTH'(bus.out_valid), 0);
        check("rmul_result", bus.result, 0);
        check("rmul_in_ready", WIDTH'(bus.in_ready), 1);
        issue(4'b0010, 1, 1, 2, 0, 0, 1, w);

        // Back-to-back single-cycle ops, one per cycle.
        issue(4'b0010, 5, 3, 8, 0, 0, 1, w);
        check("b2b_wait_add", w, 0);
        issue(4'b0110, 3, 5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, w);
        check("b2b_wait_sub", w, 0);
        issue(4'b0000, 64'hF0, 64'h3C, 64'h30, 0, 0, 1, w);
        check("b2b_wait_and", w, 0);
        issue(4'b0001, 64'hF0, 64'h0F, 64'hFF, 0, 0, 1, w);
        check("b2b_wait_or", w, 0);

        // Branch-compare style zero results.
        issue(4'b0110, 64'h1234, 64'h1234, 0, 1, 0, 1, w);
        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 1, w);

        // Multiply latency and stall; an ADD is held on in_valid meanwhile.
        issue(4'b1000, 123456, 789, 97406784, 0, 0, 1, w);
        busy_cycles = 0;
        fork
            issue(4'b0010, 10, 20, 30, 0, 0, 1, w);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (!bus.busy) break;
                    if (!bus.in_ready) busy_cycles++;
                end
                check("mul_done_out_valid", WIDTH'(bus.out_valid), 1);
            end
        join
        check("mul_stall_cycles", busy_cycles, 64);
        check("add_after_mul_wait", w, 64);

        // Backpressure holds the result; release together with a new op.
        step(2);
        bus.out_ready = 1'b0;
        issue(4'b0010, 2, 2, 4, 0, 0, 1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", WIDTH'(bus.out_valid), 1);
            check("bp_result", bus.result, 4);
            check("bp_in_ready", WIDTH'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(4'b0001, 1, 2, 3, 0, 0, 1, w);
        check("bp_release_wait", w, 0);

        // Illegal code, then a legal op clears the flag.
        issue(4'b0101, 7, 7, 0, 1, 1, 1, w);
        issue(4'b0010, 3, 4, 7, 0, 0, 1, w);

        step(4);
        check("scoreboard_drained", WIDTH'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
